lut_adr_sequencer: RTL and testbench

LUT_ADR_SEQUENCER -- requirements
Module: lut_adr_sequencer

---
 rtl/lut_adr_sequencer_if.sv | 24 ++
 rtl/lut_adr_sequencer.sv | 98 +++++++++
 tb/tb_lut_adr_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lut_adr_sequencer_if.sv
// rtl/lut_adr_sequencer_if.sv - Avalon-MM register port and LUT address stream
interface lut_adr_sequencer_if #(
  parameter int ADR_W = 11
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [ADR_W-1:0] lut_adr;
  logic             lut_adr_valid;
  logic             lut_adr_ready;
  logic             irq;

  modport master (
    output address, chipselect, write_n, writedata, lut_adr_ready,
    input  readdata, lut_adr, lut_adr_valid, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, lut_adr_ready,
    output readdata, lut_adr, lut_adr_valid, irq
  );
endinterface

// File: rtl/lut_adr_sequencer.sv
// rtl/lut_adr_sequencer.sv - register-programmed LUT address scan engine
// Walks lut_adr from BASE to LAST (wrapping mod 2^ADR_W), optionally looping.
module lut_adr_sequencer #(
  parameter int ADR_W = 11
) (
  input logic               clk,
  input logic               reset,
  lut_adr_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] base_q, last_q, adr_q, adr_d;
  logic             loop_q, irq_en_q, done_q, done_d;
  logic             wr, ctrl_wr, start_w, abort_w, clr_w, xfer, set_done, idle;
  logic             unused_wdata;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign ctrl_wr = wr && (bus.address == 2'd0);
  assign start_w = ctrl_wr & bus.writedata[0];
  assign abort_w = ctrl_wr & bus.writedata[1];
  assign clr_w   = ctrl_wr & bus.writedata[4];
  assign idle    = (state_q == IDLE);
  assign xfer    = (state_q == RUN) & bus.lut_adr_ready;
  assign unused_wdata = ^bus.writedata[31:ADR_W];

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    set_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_w && !abort_w) begin
          state_d = RUN;
          adr_d   = base_q;
        end else if (wr && bus.address == 2'd3) begin
          adr_d = bus.writedata[ADR_W-1:0];
        end
      end
      RUN: begin
        // Abort wins: a transfer in the abort cycle is accepted but the address freezes.
        if (abort_w) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (adr_q != last_q) begin
            adr_d = adr_q + ADR_W'(1);
          end else if (loop_q) begin
            adr_d = base_q;
          end else begin
            state_d  = IDLE;
            set_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = done_q;
    if (set_done) done_d = 1'b1;
    if (clr_w || (start_w && idle)) done_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      base_q   <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      done_q  <= done_d;
      if (ctrl_wr) begin
        loop_q   <= bus.writedata[2];
        irq_en_q <= bus.writedata[3];
      end
      if (wr && idle && bus.address == 2'd1) base_q <= bus.writedata[ADR_W-1:0];
      if (wr && idle && bus.address == 2'd2) last_q <= bus.writedata[ADR_W-1:0];
    end
  end

  assign bus.lut_adr       = adr_q;
  assign bus.lut_adr_valid = (state_q == RUN);
  assign bus.irq           = done_q & irq_en_q;

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = {28'd0, irq_en_q, loop_q, done_q, (state_q == RUN)};
      2'd1:    bus.readdata = 32'(base_q);
      2'd2:    bus.readdata = 32'(last_q);
      default: bus.readdata = 32'(adr_q);
    endcase
  end
endmodule

// File: tb/tb_lut_adr_sequencer.sv
// tb/tb_lut_adr_sequencer.sv - scoreboard bench for lut_adr_sequencer
module tb_lut_adr_sequencer;
  localparam int ADR_W = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lut_adr_sequencer_if #(.ADR_W(ADR_W)) bus ();
  lut_adr_sequencer #(.ADR_W(ADR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int rmode = 2;
  logic [ADR_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic reg_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    check(name, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  task automatic push_range(input logic [ADR_W-1:0] first, input int n);
    logic [ADR_W-1:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + ADR_W'(1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.lut_adr_valid === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Ready pattern generator: 0 = always accept, 1 = toggle, 2 = stall.
  initial begin
    bus.lut_adr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.lut_adr_ready = 1'b1;
        1:       bus.lut_adr_ready = ~bus.lut_adr_ready;
        default: bus.lut_adr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted address must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.lut_adr_valid === 1'b1 && bus.lut_adr_ready === 1'b1) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected actual=0x%0h required=none", bus.lut_adr);
        end else begin
          check("xfer_adr", 32'(bus.lut_adr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", 32'(bus.lut_adr_valid), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_lut_adr", 32'(bus.lut_adr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) reg_read("rst_reg", 2'(i), 32'd0);

    // Plain scan 5..8
    rmode = 0;
    reg_write(2'd1, 32'd5);
    reg_write(2'd2, 32'd8);
    push_range(11'd5, 4);
    reg_write(2'd0, 32'h1);
    wait_idle("scan");
    reg_read("scan_status", 2'd0, 32'h2);
    reg_read("scan_adr_holds_last", 2'd3, 32'd8);

    // Backpressure: same range with ready toggling
    rmode = 1;
    xfer_cnt = 0;
    push_range(11'd5, 4);
    reg_write(2'd0, 32'h1);
    reg_read("bp_done_cleared", 2'd0, 32'h1);
    wait_idle("bp");
    check("bp_xfer_count", 32'(xfer_cnt), 32'd4);
    reg_read("bp_status", 2'd0, 32'h2);

    // Wrap through zero with loop, then abort on the sixth transfer
    rmode = 0;
    reg_write(2'd1, 32'h7FE);
    reg_write(2'd2, 32'h001);
    reg_write(2'd0, 32'h4);
    exp_q.push_back(11'h7FE); exp_q.push_back(11'h7FF); exp_q.push_back(11'h000);
    exp_q.push_back(11'h001); exp_q.push_back(11'h7FE); exp_q.push_back(11'h7FF);
    reg_write(2'd0, 32'h5);
    repeat (5) @(posedge clk); #1;
    reg_write(2'd0, 32'h2);
    check("abort_valid", 32'(bus.lut_adr_valid), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    reg_read("abort_status", 2'd0, 32'h0);
    reg_read("abort_adr_frozen", 2'd3, 32'h7FF);

    // Start and abort together: nothing starts
    reg_write(2'd0, 32'h3);
    check("start_abort_valid", 32'(bus.lut_adr_valid), 32'd0);
    reg_read("start_abort_status", 2'd0, 32'h0);
    reg_read("start_abort_adr", 2'd3, 32'h7FF);

    // Single-address scan with interrupt
    reg_write(2'd1, 32'd3);
    reg_write(2'd2, 32'd3);
    reg_write(2'd0, 32'h8);
    exp_q.push_back(11'd3);
    reg_write(2'd0, 32'h9);
    wait_idle("irq_scan");
    check("irq_set", 32'(bus.irq), 32'd1);
    reg_read("irq_status", 2'd0, 32'hA);
    reg_write(2'd0, 32'h18);
    check("irq_cleared", 32'(bus.irq), 32'd0);
    reg_read("irq_clr_status", 2'd0, 32'h8);

    // Busy protection
    reg_write(2'd0, 32'h0);
    reg_write(2'd3, 32'h123);
    reg_read("direct_idle", 2'd3, 32'h123);
    check("direct_no_valid", 32'(bus.lut_adr_valid), 32'd0);
    rmode = 2;
    reg_write(2'd1, 32'h10);
    reg_write(2'd2, 32'h13);
    push_range(11'h10, 4);
    reg_write(2'd0, 32'h1);
    reg_write(2'd3, 32'h55);
    reg_write(2'd1, 32'h1);
    reg_write(2'd2, 32'h1);
    reg_write(2'd0, 32'h1);
    reg_read("busy_direct_ignored", 2'd3, 32'h10);
    reg_read("busy_base_ignored", 2'd1, 32'h10);
    reg_read("busy_last_ignored", 2'd2, 32'h13);
    reg_read("busy_status", 2'd0, 32'h1);
    rmode = 0;
    wait_idle("busy_scan");
    reg_read("busy_final_adr", 2'd3, 32'h13);

    // Asynchronous reset mid-scan
    rmode = 2;
    reg_write(2'd1, 32'h20);
    reg_write(2'd2, 32'h2F);
    reg_write(2'd0, 32'hD);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.lut_adr_valid), 32'd0);
    check("mid_rst_irq", 32'(bus.irq), 32'd0);
    check("mid_rst_lut_adr", 32'(bus.lut_adr), 32'd0);
    for (int i = 0; i < 4; i++) reg_read("mid_rst_reg", 2'(i), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    reg_read("post_rst_status", 2'd0, 32'h0);
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
